// File: rtl/ladybird_uart_rx_if.sv
// ladybird_uart_rx_if: receive-side byte stream bundle.
// Source drives o_data/o_valid, sink drives o_ready as a pop strobe.
interface ladybird_uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ready;

  modport master (
    output o_data,
    output o_valid,
    input  o_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output o_ready
  );
endinterface

// File: rtl/ladybird_uart_rx.sv
// ladybird_uart_rx: 8N1 UART receiver with a first-word-fall-through FIFO.
// Define LADYBIRD_UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module ladybird_uart_rx #(
  parameter logic [15:0] WTIME      = 16'h364,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               anrst,
  input  logic               uart_txd_in,
  ladybird_uart_rx_if.master rx,
  output logic               overrun,
  output logic               frame_err,
  input  logic               err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0]   HALF = WTIME >> 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

`ifdef LADYBIRD_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;
`endif

  state_t state, state_nxt;

  logic       rx_m;
  logic       rx_s;
  logic       rx_d;
  logic [1:0] sync_vld;
  logic       fall;

  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  sh, sh_nxt;
  logic [2:0]  bitn, bitn_nxt;
  logic        expire;
  logic        push;
  logic        ferr_set;
`ifdef LADYBIRD_UART_RX_PARITY_EN
  logic        pbad, pbad_nxt;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr;
  logic          ovr_set;

  // Two-flop synchronizer; rx_d only holds a genuinely observed line level,
  // so a line that is already low after reset never looks like a fall.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      rx_m     <= uart_txd_in;
      rx_s     <= rx_m;
      rx_d     <= rx_s & sync_vld[1];
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign expire = (cnt <= 16'd1);

  // FSM state register.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, bit timing and frame assembly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
    sh_nxt    = sh;
    bitn_nxt  = bitn;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef LADYBIRD_UART_RX_PARITY_EN
    pbad_nxt  = pbad;
`endif
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cnt_nxt   = HALF;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            state_nxt = DATA;
            cnt_nxt   = WTIME;
            bitn_nxt  = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          sh_nxt   = {rx_s, sh[7:1]};
          cnt_nxt  = WTIME;
          bitn_nxt = bitn + 3'd1;
          if (bitn == 3'd7) begin
`ifdef LADYBIRD_UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef LADYBIRD_UART_RX_PARITY_EN
      PARITY: begin
        if (expire) begin
          pbad_nxt  = ^{sh, rx_s};
          cnt_nxt   = WTIME;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          cnt_nxt = WTIME;
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef LADYBIRD_UART_RX_PARITY_EN
            push      = ~pbad;
            ferr_set  = pbad;
`else
            push      = 1'b1;
`endif
          end else begin
            state_nxt = WAIT_HIGH;
            ferr_set  = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Receive datapath registers.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      cnt  <= 16'd0;
      sh   <= 8'h00;
      bitn <= 3'd0;
`ifdef LADYBIRD_UART_RX_PARITY_EN
      pbad <= 1'b0;
`endif
    end else begin
      cnt  <= cnt_nxt;
      sh   <= sh_nxt;
      bitn <= bitn_nxt;
`ifdef LADYBIRD_UART_RX_PARITY_EN
      pbad <= pbad_nxt;
`endif
    end
  end

  assign full    = (count == FULL);
  assign pop     = rx.o_valid & rx.o_ready;
  assign wr      = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  // FIFO storage; contents are don't-care until count says otherwise.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= sh;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr)  wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  assign rx.o_valid = (count != '0);
  assign rx.o_data  = rx.o_valid ? mem[rp] : 8'h00;

  // Sticky error flags; a set in the same cycle beats the clear.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ladybird_uart_rx.sv
// tb_ladybird_uart_rx: scoreboard bench for ladybird_uart_rx.
// Frames are bit-banged at WTIME=16; expected bytes queue up as sent.
module tb_ladybird_uart_rx;

  localparam int W = 16;
`ifdef LADYBIRD_UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int STOP_C = (NB - 1) * W + 10;

  logic clk = 1'b0;
  logic anrst = 1'b0;
  logic txd = 1'b1;
  logic overrun;
  logic frame_err;
  logic err_clr = 1'b0;

  ladybird_uart_rx_if bus ();

  ladybird_uart_rx #(
    .WTIME      (16'd16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .anrst       (anrst),
    .uart_txd_in (txd),
    .rx          (bus),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic v_prev = 1'b0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid && !v_prev) rise_cyc <= cyc;
    v_prev <= bus.o_valid;
  end

  task automatic send_frame(input logic [7:0] d, input logic pflip,
                            input int pop_at, input int clr_at);
    logic [10:0] bits;
    logic [7:0]  exp;
`ifdef LADYBIRD_UART_RX_PARITY_EN
    bits = {1'b1, (^d) ^ pflip, d, 1'b0};
`else
    bits = {1'b1, 1'b1, d, 1'b0};
    if (pflip) bits[10] = 1'b1;
`endif
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int c = 0; c < NB * W; c++) begin
      txd = bits[c / W];
      bus.o_ready = (c == pop_at);
      err_clr = (c == clr_at);
      if (c == pop_at) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL pop_in_frame: queue empty, o_data=%h", bus.o_data);
        end else begin
          exp = sb.pop_front();
          if (bus.o_data !== exp) begin
            bad++;
            $display("FAIL pop_in_frame: got %h want %h", bus.o_data, exp);
          end
        end
      end
      @(posedge clk); #1;
    end
    txd = 1'b1;
    bus.o_ready = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic pop_check(input string name);
    int n;
    logic [7:0] exp;
    n = 0;
    @(posedge clk); #1;
    while (!bus.o_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!bus.o_valid) begin
      bad++;
      $display("FAIL %s: o_valid timeout got 0 want 1", name);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected byte %h", name, bus.o_data);
    end else begin
      exp = sb.pop_front();
      if (bus.o_data !== exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", name, bus.o_data, exp);
      end
      bus.o_ready = 1'b1;
      @(posedge clk); #1;
      bus.o_ready = 1'b0;
    end
  endtask

  task automatic check_bit(input string name, input logic got,
                           input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    anrst = 1'b0;
    bus.o_ready = 1'b0;
    #3;
    check_bit("rst_valid", bus.o_valid, 1'b0);
    check_bit("rst_overrun", overrun, 1'b0);
    check_bit("rst_frame_err", frame_err, 1'b0);
    total++;
    if (bus.o_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_data: got %h want 00", bus.o_data);
    end
    idle(3);
    anrst = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    rise_cyc = -1;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, -1, -1);
    total++;
    if (rise_cyc - start_cyc != STOP_C + 1) begin
      bad++;
      $display("FAIL single_latency: got %0d want %0d",
               rise_cyc - start_cyc, STOP_C + 1);
    end
    check_bit("single_overrun", overrun, 1'b0);
    check_bit("single_frame_err", frame_err, 1'b0);
    pop_check("single_data");
    check_bit("single_empty", bus.o_valid, 1'b0);
  endtask

  task automatic test_false_start();
    @(posedge clk); #1;
    txd = 1'b0;
    idle(5);
    txd = 1'b1;
    idle(3 * W);
    check_bit("glitch_valid", bus.o_valid, 1'b0);
    check_bit("glitch_frame_err", frame_err, 1'b0);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, -1, -1);
    pop_check("glitch_after");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(8'(i));
      send_frame(8'(i), 1'b0, -1, -1);
    end
    check_bit("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");
    check_bit("ovr_empty", bus.o_valid, 1'b0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check_bit("ovr_clr", overrun, 1'b0);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(8'h11 + 8'(i));
      send_frame(8'h11 + 8'(i), 1'b0, -1, -1);
    end
    send_frame(8'h15, 1'b0, STOP_C, -1);
    sb.push_back(8'h15);
    check_bit("fullpop_overrun", overrun, 1'b0);
    for (int i = 0; i < 4; i++) pop_check("fullpop_data");
    check_bit("fullpop_empty", bus.o_valid, 1'b0);
  endtask

  task automatic test_clr_race();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(8'h21 + 8'(i));
      send_frame(8'h21 + 8'(i), 1'b0, -1, -1);
    end
    send_frame(8'h25, 1'b0, -1, STOP_C);
    check_bit("race_set_wins", overrun, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("race_data");
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic test_break();
    @(posedge clk); #1;
    txd = 1'b0;
    for (int c = 0; c < 20 * W; c++) begin
      err_clr = (c == 14 * W);
      if (c == 12 * W) check_bit("break_err", frame_err, 1'b1);
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
    check_bit("break_single_err", frame_err, 1'b0);
    check_bit("break_no_push", bus.o_valid, 1'b0);
    txd = 1'b1;
    idle(2 * W);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, -1, -1);
    pop_check("break_after");
    check_bit("break_after_err", frame_err, 1'b0);
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1;
    txd = 1'b0;
    idle(4 * W);
    anrst = 1'b0;
    idle(3);
    anrst = 1'b1;
    idle(12 * W);
    check_bit("midrst_err", frame_err, 1'b0);
    check_bit("midrst_valid", bus.o_valid, 1'b0);
    txd = 1'b1;
    idle(2 * W);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, -1, -1);
    pop_check("midrst_after");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int i = 0; i < 3; i++) begin
      v = 8'($urandom_range(0, 255));
      sb.push_back(v);
      send_frame(v, 1'b0, -1, -1);
    end
    for (int i = 0; i < 3; i++) pop_check("b2b_data");
    check_bit("b2b_empty", bus.o_valid, 1'b0);
    check_bit("b2b_overrun", overrun, 1'b0);
  endtask

`ifdef LADYBIRD_UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, -1, -1);
    idle(2);
    check_bit("par_bad_err", frame_err, 1'b1);
    check_bit("par_bad_drop", bus.o_valid, 1'b0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b0, -1, -1);
    pop_check("par_good");
    check_bit("par_good_err", frame_err, 1'b0);
  endtask
`endif

  initial begin
    bus.o_ready = 1'b0;
    test_reset();
    test_single();
    test_false_start();
    test_overrun();
    test_full_pop();
    test_clr_race();
    test_break();
    test_reset_midframe();
    test_back_to_back();
`ifdef LADYBIRD_UART_RX_PARITY_EN
    test_parity();
`endif
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ladybird_uart_rx.md
LADYBIRD_UART_RX -- requirements
Module: ladybird_uart_rx

Interface
REQ-001 SHALL have parameter WTIME, default 16'h364: bit period in clk cycles; legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries; must be a power of two, 2..16.
REQ-003 SHALL have one clock and one reset, asynchronous and active-low; no other clock or reset input.
REQ-004 SHALL have port clk, input, 1: sole clock; all state is updated on its rising edge.
REQ-005 SHALL have port anrst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port uart_txd_in, input, 1: serial line from host; idle high; asynchronous to clk.
REQ-007 SHALL have port o_data, output, 8: byte at the FIFO head.
REQ-008 SHALL have port o_valid, output, 1: FIFO not empty.
REQ-009 SHALL have port o_ready, input, 1: consumer pop strobe.
REQ-010 SHALL have port overrun, output, 1: sticky flag, byte dropped because the FIFO was full.
REQ-011 SHALL have port frame_err, output, 1: sticky flag, bad stop bit (or bad parity when enabled).
REQ-012 SHALL have port err_clr, input, 1: synchronous clear of overrun and frame_err.

Function
REQ-013 SHALL pass uart_txd_in through a 2-flop synchronizer (both flops reset to 1); all further logic uses the synchronized value rx_s.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-015 IDLE: a high-to-low transition of rx_s SHALL move the FSM to START and load the bit counter with WTIME/2 (floor).
REQ-016 START: when the counter expires, rx_s=0 SHALL move the FSM to DATA with the counter at WTIME; rx_s=1 (false start) SHALL return it to IDLE with no flags set.
REQ-017 DATA: SHALL sample rx_s once per WTIME cycles, 8 bits, LSB first, into a shift register; after bit 7 it SHALL go to STOP (or to PARITY when enabled).
REQ-018 STOP: rx_s=1 at the sample point SHALL push the byte and go to IDLE; rx_s=0 SHALL drop the byte, set frame_err and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL stay in this state until rx_s=1, then go to IDLE; a line break therefore yields exactly one frame_err.
REQ-020 The bit counter SHALL be 16 bits, count down, reload at every sample point, and never wrap below zero.
REQ-021 The pushed byte SHALL be visible with o_valid=1 on the cycle after the stop-bit sample cycle when the FIFO was empty.
REQ-022 The FIFO SHALL present first-word-fall-through output: o_data is the head entry, o_valid = (count != 0).
REQ-023 A pop SHALL occur when o_valid & o_ready; o_ready while o_valid=0 SHALL have no effect.
REQ-024 A push into a full FIFO SHALL be dropped and set overrun, unless a pop occurs in the same cycle, in which case the push SHALL be accepted and count SHALL be unchanged.
REQ-025 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-026 err_clr SHALL clear both flags, except that a set event in the same cycle SHALL win.
REQ-027 o_data SHALL hold a stable value while o_valid=1 and no pop occurs.

Reset
REQ-028 anrst=0 SHALL immediately force: FSM to IDLE, counter=0, synchronizer=1, pointers/count=0, o_valid=0, o_data=8'h00, overrun=0, frame_err=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release, a line still low SHALL NOT be taken as a start bit until a high-to-low transition is seen.

Configuration
REQ-030 With LADYBIRD_UART_RX_PARITY_EN defined, the block SHALL expect an even-parity bit after bit 7, sampled in PARITY.
REQ-031 With the macro defined, a parity mismatch SHALL drop the byte and set frame_err, and the FSM SHALL still check the stop bit before going to IDLE or WAIT_HIGH.
REQ-032 Without the macro, the frame SHALL be 8N1, the PARITY state SHALL not exist, and ports SHALL be identical.

Verification
REQ-033 Scenario: WTIME=16, send 8'hA5 8N1, o_ready=0 -> o_valid=1 with o_data=8'hA5, 1 cycle after the stop sample; both flags 0.
REQ-034 Scenario: WTIME=16, 0-pulse of 5 cycles on the line -> no push, FSM returns to IDLE, frame_err=0.
REQ-035 Scenario: FIFO_DEPTH=4, send bytes 01..05 with o_ready=0 -> FIFO holds 01..04, overrun=1; pops return 01,02,03,04 in order.
REQ-036 Scenario: FIFO full, 5th stop sample coincides with a pop -> 5th byte accepted, overrun=0, count stays 4.
REQ-037 Scenario: line held low for 20 bit times -> exactly one frame_err, no push; after the line returns high, byte 8'h3C is received correctly.
REQ-038 Scenario: with the macro defined, send 8'h07 with parity bit 0 -> byte dropped, frame_err=1; send 8'h07 with parity bit 1 -> byte received.
